// File: rtl/cmp_pkg.sv
// Shared types and helpers for the shared-comparator arbiter.
// Holds FSM encoding, default sizes and the round-robin picker.
package cmp_pkg;

  localparam int DATA_W_DEF = 8;
  localparam int N_REQ_DEF  = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CMP  = 2'd1,
    RESP = 2'd2
  } state_t;

  // First set bit of req at or after ptr, wrapping at n.
  // Returns ptr when no bit is set (caller gates on |req).
  function automatic int rr_pick(
    input logic [15:0] req,
    input int          ptr,
    input int          n
  );
    int   res;
    int   idx;
    logic found;
    res   = ptr;
    found = 1'b0;
    for (int i = 0; i < 16; i++) begin
      idx = (ptr + i) % n;
      if (!found && i < n && req[idx[3:0]]) begin
        res   = idx;
        found = 1'b1;
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/cmp_gt_reg.sv
// Registered unsigned greater-than: gt <= (a > b) when en.
// Ports: CLK, RST (sync, high), en, a, b -> gt.
module cmp_gt_reg #(
  parameter int W = 8
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         en,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         gt
);

  always_ff @(posedge CLK) begin
    if (RST) begin
      gt <= 1'b0;
    end else if (en) begin
      gt <= (a > b);
    end
  end

endmodule

// File: rtl/cmp_share_arbiter.sv
// Round-robin share of one registered A>B comparator among N_REQ requesters.
// Ports: CLK, RST, req/a_in/b_in -> gnt; rsp_valid/rsp_ready/rsp_id/rsp_gt; busy.
module cmp_share_arbiter
  import cmp_pkg::*;
#(
  parameter  int N_REQ  = N_REQ_DEF,
  parameter  int DATA_W = DATA_W_DEF,
  localparam int ID_W   = $clog2(N_REQ)
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic [N_REQ-1:0]        req,
  input  logic [N_REQ*DATA_W-1:0] a_in,
  input  logic [N_REQ*DATA_W-1:0] b_in,
  output logic [N_REQ-1:0]        gnt,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [ID_W-1:0]         rsp_id,
  output logic                    rsp_gt,
  output logic                    busy
);

  state_t              state_q, state_d;
  logic [ID_W-1:0]     ptr_q, ptr_d;
  logic [ID_W-1:0]     id_q, id_d;
  logic [ID_W-1:0]     win, id_nxt;
  logic [N_REQ-1:0]    gnt_q, gnt_d;
  logic                vld_q, vld_d;
  logic                busy_q, ld, cmp_en;
  logic [DATA_W-1:0]   a_q, b_q, a_sel, b_sel;
  int                  pick;

  assign pick = rr_pick(16'(req), int'(ptr_q), N_REQ);
  assign win  = ID_W'(pick);

  always_comb begin
    a_sel = '0;
    b_sel = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (win == ID_W'(i)) begin
        a_sel = a_in[i*DATA_W +: DATA_W];
        b_sel = b_in[i*DATA_W +: DATA_W];
      end
    end
  end

  assign id_nxt = (id_q == ID_W'(N_REQ - 1))
                ? '0 : id_q + ID_W'(1);

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    id_d    = id_q;
    gnt_d   = '0;
    vld_d   = vld_q;
    ld      = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (|req) begin
          id_d    = win;
          gnt_d   = N_REQ'(1) << win;
          ld      = 1'b1;
          state_d = CMP;
        end
      end
      CMP: begin
        vld_d   = 1'b1;
        state_d = RESP;
      end
      RESP: begin
        // Pointer moves only here, so stalls freeze arbitration.
        if (vld_q && rsp_ready) begin
          vld_d   = 1'b0;
          ptr_d   = id_nxt;
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      id_q    <= '0;
      gnt_q   <= '0;
      vld_q   <= 1'b0;
      busy_q  <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      id_q    <= id_d;
      gnt_q   <= gnt_d;
      vld_q   <= vld_d;
      busy_q  <= (state_d != IDLE);
      if (ld) begin
        a_q <= a_sel;
        b_q <= b_sel;
      end
    end
  end

  assign cmp_en = (state_q == CMP);

  cmp_gt_reg #(
    .W (DATA_W)
  ) u_gt (
    .CLK (CLK),
    .RST (RST),
    .en  (cmp_en),
    .a   (a_q),
    .b   (b_q),
    .gt  (rsp_gt)
  );

  assign gnt       = gnt_q;
  assign rsp_valid = vld_q;
  assign rsp_id    = id_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_cmp_share_arbiter.sv
// Self-checking bench for cmp_share_arbiter.
// Vector table, directed corner sequences, then random traffic vs a model.
module tb_cmp_share_arbiter;

  localparam int N  = 4;
  localparam int W  = 8;
  localparam int IW = 2;

  logic            CLK = 1'b0;
  logic            RST;
  logic [N-1:0]    req;
  logic [N*W-1:0]  a_in, b_in;
  logic [N-1:0]    gnt;
  logic            rsp_valid, rsp_ready;
  logic [IW-1:0]   rsp_id;
  logic            rsp_gt, busy;

  int n_cmp = 0;
  int n_bad = 0;

  cmp_share_arbiter #(.N_REQ(N), .DATA_W(W)) dut (
    .CLK       (CLK),
    .RST       (RST),
    .req       (req),
    .a_in      (a_in),
    .b_in      (b_in),
    .gnt       (gnt),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_gt    (rsp_gt),
    .busy      (busy)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [N-1:0]  req;
    logic [W-1:0]  a;
    logic [W-1:0]  b;
    logic [N-1:0]  gnt;
    logic [IW-1:0] id;
    logic          gt;
  } vec_t;

  vec_t tbl [8];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic set_slice(input int i, input logic [W-1:0] a,
                           input logic [W-1:0] b);
    a_in[i*W +: W] = a;
    b_in[i*W +: W] = b;
  endtask

  task automatic chk_zero(input string nm);
    chk({nm, " gnt"}, 32'(gnt), 0);
    chk({nm, " vld"}, 32'(rsp_valid), 0);
    chk({nm, " id"}, 32'(rsp_id), 0);
    chk({nm, " gt"}, 32'(rsp_gt), 0);
    chk({nm, " busy"}, 32'(busy), 0);
  endtask

  task automatic do_reset();
    RST = 1'b1;
    req = '0;
    rsp_ready = 1'b1;
    tick();
    tick();
    RST = 1'b0;
  endtask

  task automatic txn(input int k);
    string nm;
    nm = $sformatf("vec%0d", k);
    for (int i = 0; i < N; i++) set_slice(i, tbl[k].a, tbl[k].b);
    req = tbl[k].req;
    rsp_ready = 1'b1;
    tick();
    chk({nm, " gnt"}, 32'(gnt), 32'(tbl[k].gnt));
    chk({nm, " busy"}, 32'(busy), 1);
    chk({nm, " vld0"}, 32'(rsp_valid), 0);
    req = '0;
    tick();
    chk({nm, " gnt0"}, 32'(gnt), 0);
    chk({nm, " vld"}, 32'(rsp_valid), 1);
    chk({nm, " id"}, 32'(rsp_id), 32'(tbl[k].id));
    chk({nm, " gt"}, 32'(rsp_gt), 32'(tbl[k].gt));
    tick();
    chk({nm, " done"}, 32'(rsp_valid), 0);
    chk({nm, " idle"}, 32'(busy), 0);
  endtask

  // random-phase model state
  int   cyc, g_cyc, m_id, m_ptr, n_g;
  bit   outst, m_gt, was_idle;
  logic [N-1:0] exp_gnt, seen;

  initial begin
    tbl[0] = '{4'b0001, 8'd200, 8'd100, 4'b0001, 2'd0, 1'b1};
    tbl[1] = '{4'b0010, 8'h55,  8'h55,  4'b0010, 2'd1, 1'b0};
    tbl[2] = '{4'b0100, 8'hFF,  8'h00,  4'b0100, 2'd2, 1'b1};
    tbl[3] = '{4'b1000, 8'h00,  8'hFF,  4'b1000, 2'd3, 1'b0};
    tbl[4] = '{4'b1010, 8'h80,  8'h7F,  4'b0010, 2'd1, 1'b1};
    tbl[5] = '{4'b0011, 8'h01,  8'h02,  4'b0001, 2'd0, 1'b0};
    tbl[6] = '{4'b1001, 8'h7F,  8'h80,  4'b1000, 2'd3, 1'b0};
    tbl[7] = '{4'b1111, 8'h10,  8'h0F,  4'b0001, 2'd0, 1'b1};

    a_in = '0;
    b_in = '0;
    do_reset();
    chk_zero("reset");

    for (int k = 0; k < 8; k++) txn(k);

    // all four held high: order 0,1,2,3,0, three cycles apart
    do_reset();
    for (int i = 0; i < N; i++) set_slice(i, W'(i * 50 + 10), 8'd60);
    req = '1;
    for (int j = 0; j < 5; j++) begin
      tick();
      chk($sformatf("rr%0d gnt", j), 32'(gnt), 32'(1 << (j % N)));
      tick();
      chk($sformatf("rr%0d vld", j), 32'(rsp_valid), 1);
      chk($sformatf("rr%0d id", j), 32'(rsp_id), 32'(j % N));
      chk($sformatf("rr%0d gt", j), 32'(rsp_gt), 32'((j % N) >= 2));
      tick();
    end

    // backpressure: pointer now 1
    set_slice(1, 8'h90, 8'h10);
    set_slice(2, 8'h05, 8'h06);
    set_slice(3, 8'hFE, 8'hFD);
    set_slice(0, 8'h00, 8'h00);
    req = 4'b0010;
    rsp_ready = 1'b0;
    tick();
    chk("bp gnt", 32'(gnt), 32'h2);
    req = 4'b1101;
    tick();
    for (int j = 0; j < 6; j++) begin
      chk($sformatf("bp%0d vld", j), 32'(rsp_valid), 1);
      chk($sformatf("bp%0d id", j), 32'(rsp_id), 1);
      chk($sformatf("bp%0d gt", j), 32'(rsp_gt), 1);
      chk($sformatf("bp%0d gnt", j), 32'(gnt), 0);
      if (j < 5) tick();
    end
    rsp_ready = 1'b1;
    tick();
    chk("bp hs vld", 32'(rsp_valid), 0);
    chk("bp hs gnt", 32'(gnt), 0);
    tick();
    chk("bp next gnt", 32'(gnt), 32'h4);
    req = '0;
    tick();
    chk("bp next gt", 32'(rsp_gt), 0);
    tick();

    // wrap: pointer 3, req 1001 -> 3 then 0
    req = 4'b1001;
    tick();
    chk("wrap gnt3", 32'(gnt), 32'h8);
    req = 4'b0001;
    tick();
    chk("wrap id3", 32'(rsp_id), 3);
    tick();
    tick();
    chk("wrap gnt0", 32'(gnt), 32'h1);
    req = '0;
    tick();
    chk("wrap id0", 32'(rsp_id), 0);
    chk("wrap gt0", 32'(rsp_gt), 0);
    tick();

    // reset in CMP, pointer 1 beforehand
    set_slice(0, 8'hC0, 8'h0C);
    set_slice(1, 8'h01, 8'h00);
    req = 4'b0011;
    tick();
    chk("rc gnt", 32'(gnt), 32'h2);
    RST = 1'b1;
    tick();
    chk_zero("rst cmp");
    RST = 1'b0;
    tick();
    chk("rc regrant", 32'(gnt), 32'h1);
    tick();
    chk("rr vld", 32'(rsp_valid), 1);
    chk("rr gt", 32'(rsp_gt), 1);
    RST = 1'b1;
    tick();
    chk_zero("rst resp");
    RST = 1'b0;
    tick();
    chk("rr regrant", 32'(gnt), 32'h1);
    req = '0;
    tick();
    tick();

    // random traffic vs transaction-level model
    do_reset();
    outst = 1'b0;
    m_ptr = 0;
    g_cyc = -10;
    m_id = 0;
    m_gt = 1'b0;
    cyc = 0;
    n_g = 0;
    seen = '0;
    for (int t = 0; t < 1500; t++) begin
      tick();
      cyc++;
      if (RST) begin
        outst = 1'b0;
        m_ptr = 0;
        chk_zero("rnd rst");
      end else begin
        was_idle = !outst;
        if (outst && (cyc - 1) > g_cyc && rsp_ready) begin
          outst = 1'b0;
          m_ptr = (m_id + 1) % N;
        end
        exp_gnt = '0;
        if (was_idle && req != 0) begin
          for (int k = 0; k < N; k++) begin
            int j;
            j = (m_ptr + k) % N;
            if (req[j] && exp_gnt == 0) begin
              exp_gnt = N'(1) << j;
              m_id = j;
              m_gt = a_in[j*W +: W] > b_in[j*W +: W];
            end
          end
          outst = 1'b1;
          g_cyc = cyc;
          n_g++;
        end
        chk("rnd gnt", 32'(gnt), 32'(exp_gnt));
        chk("rnd vld", 32'(rsp_valid), 32'(outst && cyc > g_cyc));
        chk("rnd busy", 32'(busy), 32'(outst));
        if (outst && cyc > g_cyc) begin
          chk("rnd id", 32'(rsp_id), 32'(m_id));
          chk("rnd gt", 32'(rsp_gt), 32'(m_gt));
        end
      end
      req = req & ~seen;
      seen = gnt;
      for (int i = 0; i < N; i++) begin
        if (!req[i] && !seen[i] && $urandom_range(3) == 0) begin
          logic [W-1:0] ra, rb;
          ra = W'($urandom);
          rb = ($urandom_range(3) == 0) ? ra : W'($urandom);
          set_slice(i, ra, rb);
          req[i] = 1'b1;
        end
      end
      rsp_ready = ($urandom_range(3) != 0);
      RST = ($urandom_range(149) == 0);
    end
    chk("rnd grants", 32'(n_g > 50), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
